// File: rtl/mux_arb_pkg.sv
// ============================================================================
//  Module : mux_arb_pkg
//  Brief  : Shared types and constants for the MUX4x1 round-robin arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
//  Module : rr_pick4
//  Brief  : Combinational round-robin picker; first set req after 'last'.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] w_pos;

    // Walk from the lowest priority slot back to the highest so the
    // highest-priority set bit is the final one written.
    always_comb begin
        found = 1'b0;
        idx   = last;
        w_pos = last;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_pos = last + SEL_W'(i) + 2'd1;
            if (req[w_pos]) begin
                found = 1'b1;
                idx   = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
//  Module : mux4_rr_arbiter
//  Brief  : Round-robin arbiter sharing a MUX4x1 between four requesters.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] c_hold_max  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt,   w_gnt_nxt;
    logic [SEL_W-1:0]   r_sel,   w_sel_nxt;
    logic [SEL_W-1:0]   r_last,  w_last_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic               r_busy;
    logic               r_timeout, w_timeout_nxt;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;

    rr_pick4 u_pick (
        .req   (req),
        .last  (r_last),
        .found (w_found),
        .idx   (w_idx)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_sel_nxt     = r_sel;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE, TURN: begin
                if (w_found) begin
                    w_gnt_nxt   = NUM_REQ'(1) << w_idx;
                    w_sel_nxt   = w_idx;
                    w_last_nxt  = w_idx;
                    w_cnt_nxt   = '0;
                    w_state_nxt = GRANT;
                end else begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (r_cnt != c_hold_max) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                // Owner release is checked first so it wins over pre-emption.
                if (!req[r_sel]) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = TURN;
                end else if ((MAX_HOLD != 0) && (r_cnt == c_hold_last) && (|(req & ~r_gnt))) begin
                    w_timeout_nxt = 1'b1;
                    w_gnt_nxt     = '0;
                    w_state_nxt   = TURN;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_sel     <= '0;
            r_last    <= SEL_W'(NUM_REQ - 1);
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_sel     <= w_sel_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= |w_gnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
//  Module : tb_mux4_rr_arbiter
//  Brief  : Self-checking bench for mux4_rr_arbiter (MAX_HOLD = 8).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic       rn;
        exp_t       e;
    } vec_t;

    exp_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    int    stepno = 0;
    string phase  = "init";

    int         m_state, m_last, m_cnt, m_sel;
    logic [3:0] m_gnt;
    logic       m_to;

    task automatic model(input logic [3:0] r, input logic rn);
        bit found;
        int w;
        if (!rn) begin
            m_state = 0; m_last = 3; m_cnt = 0; m_gnt = 4'b0; m_sel = 0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_state == 1) begin
            if (!r[m_sel]) begin
                m_gnt = 4'b0; m_state = 2;
            end else if (m_cnt == MAX_HOLD - 1 && (r & ~m_gnt) != 4'b0) begin
                m_to = 1'b1; m_gnt = 4'b0; m_state = 2;
            end
            if (m_cnt < MAX_HOLD) m_cnt++;
        end else begin
            found = 1'b0; w = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && r[(m_last + k) % 4]) begin
                    found = 1'b1; w = (m_last + k) % 4;
                end
            end
            if (found) begin
                m_gnt = 4'(1 << w); m_sel = w; m_last = w; m_cnt = 0; m_state = 1;
            end else begin
                m_gnt = 4'b0; m_state = 0;
            end
        end
    endtask

    task automatic apply(input logic [3:0] r, input logic rn, input exp_t e);
        exp_t g;
        req   = r;
        rst_n = rn;
        sb.push_back(e);
        @(posedge clk);
        #1;
        stepno++;
        g = sb.pop_front();
        checks++;
        if (gnt !== g.gnt || sel !== g.sel || busy !== g.busy || timeout !== g.to) begin
            errors++;
            $display("FAIL %s step %0d: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
                     phase, stepno, gnt, sel, busy, timeout, g.gnt, g.sel, g.busy, g.to);
        end
        checks++;
        if (!$onehot0(gnt) || busy !== (|gnt)) begin
            errors++;
            $display("FAIL %s onehot step %0d: got gnt=%b busy=%b, want one-hot/zero gnt with busy==|gnt",
                     phase, stepno, gnt, busy);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rn);
        exp_t e;
        model(r, rn);
        e.gnt = m_gnt; e.sel = 2'(m_sel); e.busy = (m_gnt != 4'b0); e.to = m_to;
        apply(r, rn, e);
    endtask

    task automatic tstep(input vec_t v);
        model(v.req, v.rn);
        apply(v.req, v.rn, v.e);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    vec_t t1[6];
    vec_t t5[5];
    int   to_cnt;

    initial begin
        // reset, grant 0, release, TURN, grant 2, release, idle
        t1[0] = '{4'b0000, 1'b0, '{4'b0000, 2'd0, 1'b0, 1'b0}};
        t1[1] = '{4'b0101, 1'b1, '{4'b0001, 2'd0, 1'b1, 1'b0}};
        t1[2] = '{4'b0100, 1'b1, '{4'b0000, 2'd0, 1'b0, 1'b0}};
        t1[3] = '{4'b0100, 1'b1, '{4'b0100, 2'd2, 1'b1, 1'b0}};
        t1[4] = '{4'b0000, 1'b1, '{4'b0000, 2'd2, 1'b0, 1'b0}};
        t1[5] = '{4'b0000, 1'b1, '{4'b0000, 2'd2, 1'b0, 1'b0}};
        // reset during a grant to 3, then re-grant on release
        t5[0] = '{4'b0000, 1'b0, '{4'b0000, 2'd0, 1'b0, 1'b0}};
        t5[1] = '{4'b1000, 1'b1, '{4'b1000, 2'd3, 1'b1, 1'b0}};
        t5[2] = '{4'b1000, 1'b1, '{4'b1000, 2'd3, 1'b1, 1'b0}};
        t5[3] = '{4'b1000, 1'b0, '{4'b0000, 2'd0, 1'b0, 1'b0}};
        t5[4] = '{4'b1000, 1'b1, '{4'b1000, 2'd3, 1'b1, 1'b0}};

        rst_n = 1'b0;
        req   = 4'b0;

        phase = "basic";
        for (int i = 0; i < 6; i++) tstep(t1[i]);

        phase = "rotate";
        step(4'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 1'b1);
            check_int($sformatf("rotate order %0d", i), int'(sel), i % 4);
            step(4'hF, 1'b1);
            step(4'hF & ~4'(1 << m_sel), 1'b1);
        end

        phase = "hold_limit";
        step(4'b0, 1'b0);
        to_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0011, 1'b1);
            if (timeout) to_cnt++;
        end
        check_int("hold_limit timeout pulses", to_cnt, 2);

        phase = "single_owner";
        step(4'b0, 1'b0);
        to_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0100, 1'b1);
            if (timeout) to_cnt++;
        end
        check_int("single_owner timeout pulses", to_cnt, 0);

        phase = "reset_in_grant";
        for (int i = 0; i < 5; i++) tstep(t5[i]);

        phase = "release_at_limit";
        step(4'b0, 1'b0);
        step(4'b0011, 1'b1);
        for (int i = 0; i < 7; i++) step(4'b0011, 1'b1);
        step(4'b0010, 1'b1);
        check_int("release_at_limit timeout", int'(timeout), 0);
        step(4'b0010, 1'b1);
        check_int("release_at_limit next owner", int'(gnt), 2);

        phase = "random";
        for (int i = 0; i < 1000; i++) step(4'($urandom_range(0, 15)), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
